// File: rtl/ser_pkg.sv
// Shared types and helpers for the frame serializer.
//   ser_state_e : serializer FSM encoding (S_IDLE / S_SHIFT)
//   calc_cnt_w  : bit-counter / Frame_bits width for a given maximum data width
//   clamp_len   : maps a requested frame length onto 1..data_w
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_e;

  // Wide enough to hold the value data_w itself, not only data_w-1.
  function automatic int unsigned calc_cnt_w(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

  // A length of 0 or anything past the word width means "whole word".
  function automatic int unsigned clamp_len(input int unsigned frame_bits,
                                            input int unsigned data_w);
    if ((frame_bits == 0) || (frame_bits > data_w)) begin
      return data_w;
    end
    return frame_bits;
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry {data,len} holding register in front of the shifter.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_wr           : capture i_data / i_len this edge
//   i_data, i_len  : word and its clamped frame length
//   i_rd           : stored word is moving to the shifter this edge
//   o_full         : entry holds a word
//   o_data, o_len  : stored word and its frame length
module ser_hold_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_rd,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_len
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_len;

  // A write on the same edge as a read wins: the old word leaves, the new one stays.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_len  <= '0;
    end else begin
      if (i_wr) begin
        r_data <= i_data;
        r_len  <= i_len;
      end
      if (i_wr) begin
        r_full <= 1'b1;
      end else if (i_rd) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_len  = r_len;

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial shifter with runtime frame length, selectable bit order
// and a one-entry hold buffer so the next word can be accepted mid-frame.
// Optional feature macro: SER_PARITY_EN (adds Par_odd / Par_bit).
// Ports:
//   CLK, Reset   : clock (rising edge), async active-low reset
//   Data         : word to send; bits at or above the frame length are ignored
//   Data_valid   : Data valid; transfer when Data_valid && Data_ready
//   Data_ready   : hold buffer empty
//   Frame_bits   : bits in this frame (0 or > DATA_W means DATA_W)
//   Ser_EN       : bit tick, advance one bit while shifting
//   Par_odd      : [SER_PARITY_EN] 0 even parity, 1 odd parity
//   Par_bit      : [SER_PARITY_EN] parity of the frame being shifted
//   Ser_data     : current serial bit (0 while idle)
//   Busy         : shifting a frame
//   Ser_done     : one-cycle pulse after the last bit's tick
module frame_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned CNT_W    = calc_cnt_w(DATA_W)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data,
  input  logic              Data_valid,
  output logic              Data_ready,
  input  logic [CNT_W-1:0]  Frame_bits,
  input  logic              Ser_EN,
`ifdef SER_PARITY_EN
  input  logic              Par_odd,
  output logic              Par_bit,
`endif
  output logic              Ser_data,
  output logic              Busy,
  output logic              Ser_done
);

  ser_state_e        r_state;
  ser_state_e        w_state_nxt;

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_len;
  logic              r_done;

  logic              w_hold_full;
  logic [DATA_W-1:0] w_hold_data;
  logic [CNT_W-1:0]  w_hold_len;

  logic [CNT_W-1:0]  w_len_in;
  logic              w_last;
  logic              w_load;
  logic              w_bypass;
  logic              w_capture;
  logic              w_drain;
  logic [DATA_W-1:0] w_src_data;
  logic [CNT_W-1:0]  w_src_len;
  logic [CNT_W-1:0]  w_shamt;
  logic [DATA_W-1:0] w_load_word;
  logic [DATA_W-1:0] w_shift_nxt;

  // Length is clamped once, at the input, and travels with the word.
  assign w_len_in = CNT_W'(clamp_len(32'(Frame_bits), DATA_W));

  ser_hold_buf #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_hold (
    .i_clk   (CLK),
    .i_rst_n (Reset),
    .i_wr    (w_capture),
    .i_data  (Data),
    .i_len   (w_len_in),
    .i_rd    (w_drain),
    .o_full  (w_hold_full),
    .o_data  (w_hold_data),
    .o_len   (w_hold_len)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus load / capture / drain decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    w_load      = 1'b0;
    w_bypass    = 1'b0;
    w_capture   = 1'b0;
    w_drain     = 1'b0;

    w_last = (r_state == S_SHIFT) && Ser_EN && (r_count == (r_len - CNT_W'(1)));

    // A load can start from idle or back-to-back on the last bit's tick.
    if ((r_state == S_IDLE) || w_last) begin
      w_load = w_hold_full || Data_valid;
    end
    w_drain   = w_load && w_hold_full;
    w_bypass  = w_load && !w_hold_full;
    w_capture = Data_valid && !w_hold_full && !w_bypass;

    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last && !w_load) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word source and shifter image (MSB-first words are left-aligned so the
  // frame's top bit sits in the output position).
  always_comb begin
    w_src_data  = w_hold_full ? w_hold_data : Data;
    w_src_len   = w_hold_full ? w_hold_len  : w_len_in;
    w_shamt     = CNT_W'(DATA_W) - w_src_len;
    w_load_word = w_src_data;
    w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
    if (MSB_FIRST) begin
      w_load_word = w_src_data << w_shamt;
      w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
    end
  end

  // Shifter, bit counter and done pulse; the shifter is cleared on the way
  // to idle so the serial line rests at 0.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_shift <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_shift <= w_load_word;
        r_count <= '0;
        r_len   <= w_src_len;
      end else if (w_last) begin
        r_shift <= '0;
        r_count <= '0;
      end else if ((r_state == S_SHIFT) && Ser_EN) begin
        r_shift <= w_shift_nxt;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef SER_PARITY_EN
  logic [DATA_W-1:0] w_len_mask;
  logic              w_par_nxt;
  logic              r_par;

  // Parity over the frame's bits only.
  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < int'(w_src_len)) begin
        w_len_mask[i] = 1'b1;
      end
    end
    w_par_nxt = (^(w_src_data & w_len_mask)) ^ Par_odd;
  end

  // Parity is taken at load and held for the whole frame.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= w_par_nxt;
    end
  end

  assign Par_bit = r_par;
`endif

  assign Data_ready = !w_hold_full;
  assign Ser_data   = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
  assign Busy       = (r_state == S_SHIFT);
  assign Ser_done   = r_done;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: an LSB-first and an MSB-first instance share all
// inputs; a scoreboard queue holds the expected bits of every accepted word.
module tb_frame_serializer;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Data = 8'h00;
  logic       Data_valid = 1'b0;
  logic [3:0] Frame_bits = 4'd0;
  logic       Ser_EN = 1'b0;

  logic l_ready, l_ser, l_busy, l_done;
  logic m_ready, m_ser, m_busy, m_done;
`ifdef SER_PARITY_EN
  logic Par_odd = 1'b0;
  logic l_par, m_par;
`endif

  typedef struct packed {
    logic bl;
    logic bm;
    logic first;
    logic last;
    logic par;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic done_pend = 1'b0;
  int   ticks = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   en_mode = 0;
  int   en_cnt = 0;

  frame_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .Reset(Reset), .Data(Data), .Data_valid(Data_valid),
    .Data_ready(l_ready), .Frame_bits(Frame_bits), .Ser_EN(Ser_EN),
`ifdef SER_PARITY_EN
    .Par_odd(Par_odd), .Par_bit(l_par),
`endif
    .Ser_data(l_ser), .Busy(l_busy), .Ser_done(l_done)
  );

  frame_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .Reset(Reset), .Data(Data), .Data_valid(Data_valid),
    .Data_ready(m_ready), .Frame_bits(Frame_bits), .Ser_EN(Ser_EN),
`ifdef SER_PARITY_EN
    .Par_odd(Par_odd), .Par_bit(m_par),
`endif
    .Ser_data(m_ser), .Busy(m_busy), .Ser_done(m_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected bit stream for both orders plus parity.
  function automatic void push_word(input logic [7:0] d, input logic [3:0] fb);
    int   len;
    logic p;
    exp_t e;
    len = ((fb == 4'd0) || (fb > 4'd8)) ? 8 : int'(fb);
    p = 1'b0;
`ifdef SER_PARITY_EN
    p = Par_odd;
`endif
    for (int k = 0; k < len; k++) p = p ^ d[k];
    for (int k = 0; k < len; k++) begin
      e.bl    = d[k];
      e.bm    = d[len-1-k];
      e.first = (k == 0);
      e.last  = (k == len - 1);
      e.par   = p;
      q.push_back(e);
    end
  endfunction

  // Bit-tick generator, driven just after the rising edge.
  always @(posedge CLK) begin
    #1;
    case (en_mode)
      0: Ser_EN = 1'b0;
      1: begin
        en_cnt = (en_cnt == 2) ? 0 : en_cnt + 1;
        Ser_EN = (en_cnt == 0);
      end
      2: Ser_EN = ($urandom_range(0, 1) == 1);
      default: Ser_EN = 1'b1;
    endcase
  end

  // Monitor on the falling edge: done pulse, bit stream, no-gap reload.
  always @(negedge CLK) begin
    if (Reset === 1'b1) begin
      check("done_lsb", 32'(l_done), 32'(done_pend));
      check("done_msb", 32'(m_done), 32'(done_pend));
      if (done_pend) begin
        check("busy_after_done", 32'(l_busy), 32'(q.size() != 0));
        check("busy_after_done_m", 32'(m_busy), 32'(q.size() != 0));
      end
      done_pend = 1'b0;
      if (l_busy && Ser_EN) begin
        if (q.size() == 0) begin
          check("extra_bit", 32'(1), 32'(0));
        end else begin
          mon_e = q.pop_front();
          check("bit_lsb", 32'(l_ser), 32'(mon_e.bl));
          check("bit_msb", 32'(m_ser), 32'(mon_e.bm));
          check("busy_msb", 32'(m_busy), 32'(1));
`ifdef SER_PARITY_EN
          if (mon_e.first) begin
            check("par_lsb", 32'(l_par), 32'(mon_e.par));
            check("par_msb", 32'(m_par), 32'(mon_e.par));
          end
`endif
          if (mon_e.last) done_pend = 1'b1;
          ticks++;
        end
      end
    end
  end

  // Offer one word; called and returns at posedge+1.
  task automatic send(input logic [7:0] d, input logic [3:0] fb);
    int n;
    n = 0;
    Data = d;
    Frame_bits = fb;
    Data_valid = 1'b1;
    while (!l_ready && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!l_ready) begin
      check("send_timeout", 32'(0), 32'(1));
      Data_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    push_word(d, fb);
    #1;
    Data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || l_busy || done_pend) && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("idle_timeout", 32'(n < 3000), 32'(1));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {30'd0, l_busy, m_busy}, 32'(0));
    check({tag, "_ser"}, {30'd0, l_ser, m_ser}, 32'(0));
    check({tag, "_done"}, {30'd0, l_done, m_done}, 32'(0));
    check({tag, "_ready"}, {30'd0, l_ready, m_ready}, 32'(3));
`ifdef SER_PARITY_EN
    check({tag, "_par"}, {30'd0, l_par, m_par}, 32'(0));
`endif
  endtask

  initial begin
    int t0;
    int n;
    repeat (2) @(posedge CLK);
    #1;
    check_quiet("reset");
    Reset = 1'b1;
    @(posedge CLK); #1;

    // LSB/MSB orders of a full byte, then a short frame.
    en_mode = 1;
    send(8'hA5, 4'd8);
    wait_idle();
    check("idle_ser", 32'(l_ser), 32'(0));
    send(8'h0F, 4'd5);
    wait_idle();

    // Second word arrives mid-frame and goes back-to-back.
    send(8'h3C, 4'd8);
    send(8'hC3, 4'd8);
    check("ready_drop", 32'(l_ready), 32'(0));
    wait_idle();

    // Length clamping and single-bit frames.
    send(8'h5A, 4'd0);
    send(8'h96, 4'd12);
    send(8'h01, 4'd1);
    send(8'h02, 4'd1);
    wait_idle();

    // Reset mid-frame aborts it without a done pulse.
    t0 = ticks;
    n = 0;
    send(8'hE7, 4'd8);
    while (ticks < t0 + 3 && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("rst_wait", 32'(ticks >= t0 + 3), 32'(1));
    #1;
    Reset = 1'b0;
    #1;
    check_quiet("midreset");
    q.delete();
    done_pend = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    send(8'hB4, 4'd8);
    wait_idle();

`ifdef SER_PARITY_EN
    Par_odd = 1'b0;
    send(8'h07, 4'd8);
    wait_idle();
    Par_odd = 1'b1;
    send(8'h07, 4'd8);
    wait_idle();
    Par_odd = 1'b0;
    send(8'hFF, 4'd4);
    wait_idle();
`endif

    // Random words, lengths and tick patterns, including a tick every cycle.
    for (int m = 2; m <= 3; m++) begin
      en_mode = m;
      for (int k = 0; k < 25; k++) begin
`ifdef SER_PARITY_EN
        Par_odd = 1'($urandom_range(0, 1));
`endif
        send(8'($urandom), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 12)) @(posedge CLK);
          #1;
        end
      end
      wait_idle();
    end

    en_mode = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_quiet("final");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
